// File: rtl/draw_fb_tile.sv
// Framebuffer tile blitter: copies one 8x8 or 16x16 sprite-sheet tile into the framebuffer.
// Optional build macro TRANSPARENT_EN suppresses writes of pixels equal to TRANSP_KEY.
module draw_fb_tile #(
  parameter int unsigned FB_WIDTH  = 168,
  parameter int unsigned FB_HEIGHT = 104,
  parameter int unsigned SHEET_W   = 128,
  parameter int unsigned PIX_W     = 4,
  parameter int unsigned FB_AW     = 15,
  parameter int unsigned SP_AW     = 14,
  parameter logic [PIX_W-1:0] TRANSP_KEY = {PIX_W{1'b0}}
) (
  input  logic             Clk,
  input  logic             RESET_N,
  input  logic             Draw_FB_EN,
  input  logic [7:0]       NewDrawX,
  input  logic [7:0]       NewDrawY,
  input  logic [6:0]       NewSpriteX,
  input  logic [6:0]       NewSpriteY,
  input  logic             is_8,
  output logic [SP_AW-1:0] sprite_addr,
  input  logic [PIX_W-1:0] sprite_data,
  output logic             fb_we,
  output logic [FB_AW-1:0] fb_addr,
  output logic [PIX_W-1:0] fb_data,
  output logic             Done_Draw_FB
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [15:0] SHEET_W16 = 16'(SHEET_W);
  localparam logic [17:0] FB_W18    = 18'(FB_WIDTH);
  localparam logic [8:0]  FB_W9     = 9'(FB_WIDTH);
  localparam logic [8:0]  FB_H9     = 9'(FB_HEIGHT);

`ifdef TRANSPARENT_EN
  localparam logic TRANSP_ON = 1'b1;
`else
  localparam logic TRANSP_ON = 1'b0;
`endif

  logic [1:0]       state_r;
  logic [7:0]       pix_cnt_r;
  logic [7:0]       dx_r, dy_r;
  logic [6:0]       sx_r, sy_r;
  logic             is8_r;
  logic [SP_AW-1:0] sprite_addr_r;
  logic             fb_we_r;
  logic [FB_AW-1:0] fb_addr_r;
  logic             done_r;

  logic [7:0]       n_last_s;
  logic [7:0]       nxt_cnt_s;
  logic [7:0]       cur_rc_s, nxt_rc_s;
  logic [SP_AW-1:0] nxt_saddr_s;
  logic [8:0]       x9_s, y9_s;
  logic             in_bounds_s;
  logic [FB_AW-1:0] dest_addr_s;
  logic             keep_s;

  // Pixel index -> {row, col} for the active tile size.
  function automatic logic [7:0] pix_rc(input logic [7:0] cnt, input logic is8);
    if (is8) begin
      return {1'b0, cnt[5:3], 1'b0, cnt[2:0]};
    end else begin
      return {cnt[7:4], cnt[3:0]};
    end
  endfunction

  function automatic logic [SP_AW-1:0] sheet_addr(input logic [6:0] sx, input logic [6:0] sy,
                                                  input logic [3:0] col, input logic [3:0] row);
    logic [15:0] y_s;
    logic [15:0] x_s;
    y_s = {9'd0, sy} + {12'd0, row};
    x_s = {9'd0, sx} + {12'd0, col};
    return SP_AW'(y_s * SHEET_W16 + x_s);
  endfunction

  // Pixel decode, next read address, destination address and clip test.
  always_comb begin
    n_last_s    = is8_r ? 8'd63 : 8'd255;
    nxt_cnt_s   = pix_cnt_r + 8'd1;
    cur_rc_s    = pix_rc(pix_cnt_r, is8_r);
    nxt_rc_s    = pix_rc(nxt_cnt_s, is8_r);
    nxt_saddr_s = sheet_addr(sx_r, sy_r, nxt_rc_s[3:0], nxt_rc_s[7:4]);
    // 9-bit sums so tiles hanging off the right/bottom edge clip instead of wrapping
    x9_s        = {1'b0, dx_r} + {5'd0, cur_rc_s[3:0]};
    y9_s        = {1'b0, dy_r} + {5'd0, cur_rc_s[7:4]};
    in_bounds_s = (x9_s < FB_W9) && (y9_s < FB_H9);
    dest_addr_s = FB_AW'({9'd0, y9_s} * FB_W18 + {9'd0, x9_s});
  end

  // Control FSM, request latches and sprite read address.
  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r       <= ST_IDLE;
      pix_cnt_r     <= 8'd0;
      dx_r          <= 8'd0;
      dy_r          <= 8'd0;
      sx_r          <= 7'd0;
      sy_r          <= 7'd0;
      is8_r         <= 1'b0;
      sprite_addr_r <= {SP_AW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (Draw_FB_EN) begin
            dx_r          <= NewDrawX;
            dy_r          <= NewDrawY;
            sx_r          <= NewSpriteX;
            sy_r          <= NewSpriteY;
            is8_r         <= is_8;
            pix_cnt_r     <= 8'd0;
            sprite_addr_r <= sheet_addr(NewSpriteX, NewSpriteY, 4'd0, 4'd0);
            state_r       <= ST_FETCH;
          end else begin
            state_r       <= ST_IDLE;
          end
        end
        ST_FETCH: begin
          pix_cnt_r <= nxt_cnt_s;
          if (pix_cnt_r == n_last_s) begin
            sprite_addr_r <= {SP_AW{1'b0}};
            state_r       <= ST_DRAIN;
          end else begin
            sprite_addr_r <= nxt_saddr_s;
            state_r       <= ST_FETCH;
          end
        end
        ST_DRAIN: state_r <= ST_DONE;
        ST_DONE:  state_r <= ST_IDLE;
        default:  state_r <= ST_IDLE;
      endcase
    end
  end

  // Write pipe: the read issued this cycle is written next cycle when ROM data arrives.
  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      fb_we_r   <= 1'b0;
      fb_addr_r <= {FB_AW{1'b0}};
    end else if (state_r == ST_FETCH) begin
      fb_we_r   <= in_bounds_s;
      fb_addr_r <= dest_addr_s;
    end else begin
      fb_we_r   <= 1'b0;
    end
  end

  // Tile-complete pulse, high for the single DONE cycle.
  always_ff @(posedge Clk or negedge RESET_N) begin
    if (!RESET_N) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == ST_DRAIN);
    end
  end

  assign keep_s       = !TRANSP_ON || (sprite_data != TRANSP_KEY);
  assign sprite_addr  = sprite_addr_r;
  assign fb_we        = fb_we_r & keep_s;
  assign fb_addr      = fb_addr_r;
  // ROM data is already registered; gating keeps fb_data at zero outside write cycles
  assign fb_data      = fb_we_r ? sprite_data : {PIX_W{1'b0}};
  assign Done_Draw_FB = done_r;

endmodule

// File: tb/tb_draw_fb_tile.sv
// Self-checking bench for draw_fb_tile: vector table, corner sequences and random tiles vs a pixel-list model.
module tb_draw_fb_tile;

  logic        Clk = 1'b0;
  logic        RESET_N = 1'b0;
  logic        Draw_FB_EN = 1'b0;
  logic [7:0]  NewDrawX = 8'd0, NewDrawY = 8'd0;
  logic [6:0]  NewSpriteX = 7'd0, NewSpriteY = 7'd0;
  logic        is_8 = 1'b1;
  logic [13:0] sprite_addr;
  logic [3:0]  sprite_data;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic [3:0]  fb_data;
  logic        Done_Draw_FB;

  int rom_mode = 0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {int c; int a; int d;} wr_t;
  wr_t wlog[$];
  int  dlog[$];
  wr_t exp_q[$];

  typedef struct {int dx; int dy; int sx; int sy; bit i8; int mode; int exp_wr; int exp_first;} vec_t;
  vec_t vt[5];

  draw_fb_tile dut (
    .Clk(Clk), .RESET_N(RESET_N), .Draw_FB_EN(Draw_FB_EN),
    .NewDrawX(NewDrawX), .NewDrawY(NewDrawY), .NewSpriteX(NewSpriteX), .NewSpriteY(NewSpriteY),
    .is_8(is_8), .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data), .Done_Draw_FB(Done_Draw_FB)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc = cyc + 1;

  function automatic logic [3:0] rom_f(input logic [13:0] a, input int m);
    case (m)
      0:       return a[3:0];
      1:       return a[0] ? a[3:0] : 4'd0;
      default: return a[3:0] ^ a[7:4] ^ a[11:8];
    endcase
  endfunction

  // Synchronous sprite ROM, one-cycle latency
  always @(posedge Clk) sprite_data <= rom_f(sprite_addr, rom_mode);

  always @(negedge Clk) begin
    if (fb_we === 1'b1) wlog.push_back('{cyc, int'(fb_addr), int'(fb_data)});
    if (Done_Draw_FB === 1'b1) dlog.push_back(cyc);
  end

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Expected writes: every pixel of the tile in raster order, written 2+k cycles after the request cycle.
  function automatic void build_exp(input int c0, input int dx, input int dy, input int sx, input int sy,
                                    input bit i8, input bit clr);
    int t;
    t = i8 ? 8 : 16;
    if (clr) exp_q.delete();
    for (int r = 0; r < t; r++) begin
      for (int c = 0; c < t; c++) begin
        int x, y, sa, d;
        bit keep;
        x = dx + c;
        y = dy + r;
        sa = ((sy + r) * 128 + sx + c) % 16384;
        d = int'(rom_f(14'(sa), rom_mode));
        keep = (x < 168) && (y < 104);
`ifdef TRANSPARENT_EN
        if (d == 0) keep = 1'b0;
`endif
        if (keep) exp_q.push_back('{c0 + 2 + r * t + c, y * 168 + x, d});
      end
    end
  endfunction

  task automatic cmp_writes(input string name);
    int bad;
    bad = -1;
    check({name, " write count"}, wlog.size(), exp_q.size());
    for (int i = 0; i < wlog.size() && i < exp_q.size(); i++) begin
      if (bad < 0 && (wlog[i].c != exp_q[i].c || wlog[i].a != exp_q[i].a || wlog[i].d != exp_q[i].d)) begin
        bad = i;
        $display("  %s write %0d: got cyc %0d addr %0d data %0d, want cyc %0d addr %0d data %0d", name, i,
                 wlog[i].c, wlog[i].a, wlog[i].d, exp_q[i].c, exp_q[i].a, exp_q[i].d);
      end
    end
    check({name, " first bad write index"}, bad, -1);
  endtask

  // Issue one tile at the current negedge; inputs are scrambled once latched, EN drops at cycle hold_k.
  task automatic do_tile(input string name, input int dx, input int dy, input int sx, input int sy,
                         input bit i8, input int hold_k, input int exp_wr, input int exp_first);
    int n, c0, first;
    n = i8 ? 64 : 256;
    first = -1;
    NewDrawX = 8'(dx); NewDrawY = 8'(dy); NewSpriteX = 7'(sx); NewSpriteY = 7'(sy);
    is_8 = i8; Draw_FB_EN = 1'b1;
    c0 = cyc;
    build_exp(c0, dx, dy, sx, sy, i8, 1'b1);
    wlog.delete(); dlog.delete();
    for (int i = 1; i <= n + 4; i++) begin
      @(negedge Clk);
      if (i == 1) begin
        first = int'(sprite_addr);
        NewDrawX = 8'($urandom); NewDrawY = 8'($urandom);
        NewSpriteX = 7'($urandom); NewSpriteY = 7'($urandom); is_8 = 1'($urandom);
      end
      if (i >= hold_k) Draw_FB_EN = 1'b0;
    end
    check({name, " first sprite_addr"}, first, exp_first);
    if (exp_wr >= 0) check({name, " writes vs table"}, wlog.size(), exp_wr);
    cmp_writes(name);
    check({name, " done pulses"}, dlog.size(), 1);
    check({name, " done cycle"}, (dlog.size() > 0) ? dlog[0] - c0 : -1, n + 2);
  endtask

  initial begin
    int tr_wr, cnt, guard, err, ndone, c0, bad, nw, nd;
`ifdef TRANSPARENT_EN
    tr_wr = 32;
`else
    tr_wr = 64;
`endif
    vt[0] = '{0,   0,   24,  16,  1'b1, 0, 64,    2072};
    vt[1] = '{160, 96,  0,   0,   1'b0, 0, 64,    0};
    vt[2] = '{164, 100, 8,   8,   1'b1, 2, 16,    1032};
    vt[3] = '{8,   8,   0,   0,   1'b1, 1, tr_wr, 0};
    vt[4] = '{0,   0,   120, 127, 1'b0, 2, 256,   16376};

    // Reset state
    repeat (3) @(negedge Clk);
    check("reset sprite_addr", int'(sprite_addr), 0);
    check("reset fb_we", int'(fb_we), 0);
    check("reset fb_addr", int'(fb_addr), 0);
    check("reset fb_data", int'(fb_data), 0);
    check("reset done", int'(Done_Draw_FB), 0);
    RESET_N = 1'b1;
    @(negedge Clk);

    for (int v = 0; v < 5; v++) begin
      rom_mode = vt[v].mode;
      do_tile($sformatf("vec%0d", v), vt[v].dx, vt[v].dy, vt[v].sx, vt[v].sy, vt[v].i8, 1,
              vt[v].exp_wr, vt[v].exp_first);
    end

    // Back-to-back: requester advances DrawX by 8 on each Done, 19 tiles
    rom_mode = 0;
    NewDrawX = 8'd0; NewDrawY = 8'd16; NewSpriteX = 7'd40; NewSpriteY = 7'd8; is_8 = 1'b1;
    Draw_FB_EN = 1'b1;
    c0 = cyc;
    exp_q.delete();
    for (int t = 0; t < 19; t++) build_exp(c0 + 67 * t, 8 * t, 16, 40, 8, 1'b1, 1'b0);
    wlog.delete(); dlog.delete();
    ndone = 0;
    for (int i = 0; i < 19 * 67 + 20; i++) begin
      @(negedge Clk);
      if (Done_Draw_FB === 1'b1) begin
        ndone++;
        if (ndone == 19) Draw_FB_EN = 1'b0;
        else NewDrawX = NewDrawX + 8'd8;
      end
    end
    check("b2b done pulses", dlog.size(), 19);
    check("b2b first done cycle", (dlog.size() > 0) ? dlog[0] - c0 : -1, 66);
    bad = 0;
    for (int i = 1; i < dlog.size(); i++) if (dlog[i] - dlog[i-1] != 67) bad++;
    check("b2b bad done spacings", bad, 0);
    cmp_writes("b2b");

    // Async reset after the 30th write
    rom_mode = 0;
    NewDrawX = 8'd0; NewDrawY = 8'd0; NewSpriteX = 7'd24; NewSpriteY = 7'd16; is_8 = 1'b1;
    Draw_FB_EN = 1'b1;
    wlog.delete(); dlog.delete();
    cnt = 0; guard = 0;
    while (cnt < 30 && guard < 200) begin
      @(negedge Clk);
      guard++;
      if (fb_we === 1'b1) cnt++;
    end
    check("rst writes before reset", cnt, 30);
    RESET_N = 1'b0;
    #1;
    check("rst fb_we drops same cycle", int'(fb_we), 0);
    check("rst sprite_addr cleared", int'(sprite_addr), 0);
    err = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      if (fb_we !== 1'b0 || Done_Draw_FB !== 1'b0) err++;
    end
    check("rst activity during reset", err, 0);
    check("rst no done from aborted tile", dlog.size(), 0);
    RESET_N = 1'b1;
    do_tile("rst restart", 0, 0, 24, 16, 1'b1, 1, 64, 2072);

    // Draw_FB_EN dropped in FETCH cycle 10, then the block must stay idle
    do_tile("en drop", 24, 40, 64, 32, 1'b1, 11, 64, 32 * 128 + 64);
    nw = wlog.size(); nd = dlog.size();
    repeat (30) @(negedge Clk);
    check("en drop idle writes", wlog.size(), nw);
    check("en drop idle dones", dlog.size(), nd);

    // Random tiles against the model
    rom_mode = 2;
    for (int r = 0; r < 8; r++) begin
      int dx, dy, sx, sy;
      bit i8;
      dx = int'($urandom_range(0, 180));
      dy = int'($urandom_range(0, 115));
      sx = int'($urandom_range(0, 127));
      sy = int'($urandom_range(0, 127));
      i8 = 1'($urandom);
      do_tile($sformatf("rand%0d", r), dx, dy, sx, sy, i8, 1, -1, (sy * 128 + sx) % 16384);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/draw_fb_tile.md
Name: draw_fb_tile

Overview:
- Framebuffer tile blitter. It is the responder side of the Draw_FB_EN / Done_Draw_FB tile-draw handshake issued by the room and entity drawers.
- On each request it copies one 8x8 tile (or 16x16 tile) from the sprite-sheet ROM into the framebuffer RAM at the requested pixel position, then pulses Done_Draw_FB for one cycle.
- It sits between the drawer FSMs and the framebuffer write port.

Parameters:
FB_WIDTH, 168, framebuffer width in pixels (21 tiles)
FB_HEIGHT, 104, framebuffer height in pixels (13 tiles)
SHEET_W, 128, sprite-sheet width in pixels
PIX_W, 4, pixel/colour-index width
FB_AW, 15, framebuffer address width
SP_AW, 14, sprite ROM address width
TRANSP_KEY, 0, colour index treated as transparent (used only with the optional feature)

Ports:
Clk  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
Draw_FB_EN  in  1  draw request, level; held high across consecutive tiles
NewDrawX  in  8  destination tile origin X, pixels
NewDrawY  in  8  destination tile origin Y, pixels
NewSpriteX  in  7  source tile origin X in sheet, pixels
NewSpriteY  in  7  source tile origin Y in sheet, pixels
is_8  in  1  1 = 8x8 tile, 0 = 16x16 tile
sprite_addr  out  SP_AW  sprite ROM read address (synchronous ROM, 1-cycle latency)
sprite_data  in  PIX_W  sprite ROM read data
fb_we  out  1  framebuffer write enable
fb_addr  out  FB_AW  framebuffer write address
fb_data  out  PIX_W  framebuffer write data
Done_Draw_FB  out  1  one-cycle tile-complete pulse

Behaviour:
- Reset: the reset is asynchronous active-low, and Clk is the only clock.
  - State goes to IDLE.
  - All counters and latches clear.
  - sprite_addr = 0, fb_we = 0, fb_addr = 0, fb_data = 0, Done_Draw_FB = 0.
- States:
  - IDLE:
    - Draw_FB_EN = 1 latches NewDrawX/Y, NewSpriteX/Y and is_8 at the clock edge.
    - Sets N = 64 (is_8 = 1) or 256 (is_8 = 0).
    - Clears pix_cnt and goes to FETCH.
  - FETCH:
    - Pixel k = pix_cnt with col = k mod T and row = k div T, where T = 8 or 16.
    - sprite_addr = (sy + row) * SHEET_W + (sx + col), truncated to SP_AW.
    - pix_cnt increments every cycle.
    - After pixel N-1 the state goes to DRAIN.
  - DRAIN: issues no read and writes the last pixel; goes to DONE.
  - DONE: Done_Draw_FB = 1 for exactly this cycle; goes to IDLE.
- Write stage:
  - A one-stage valid/address pipe tracks the read issued in cycle k.
  - In cycle k+1, fb_we = valid, fb_addr = (dy + row) * FB_WIDTH + (dx + col), fb_data = sprite_data.
- Clipping: a pixel with dx + col >= FB_WIDTH or dy + row >= FB_HEIGHT is not written (fb_we = 0). Its cycle is still consumed. Compute the sums at 9 bits so they do not wrap.
- Latency and throughput:
  - The request is sampled in IDLE cycle 0.
  - FETCH occupies cycles 1..N, DRAIN is cycle N+1, and Done_Draw_FB is asserted in cycle N+2.
  - The next IDLE is cycle N+3, giving 67 cycles per 8x8 tile and 259 per 16x16 tile.
- Handshake: the requester advances its coordinates on the Done edge. The IDLE cycle after DONE therefore sees the new coordinates, and the block re-samples then if Draw_FB_EN is still high. It never samples in the DONE cycle itself.
- Draw_FB_EN falling mid-tile is ignored: the tile completes and Done still pulses.
- Input changes after latching are ignored until the next IDLE.
- Reset asserted mid-tile: outputs drop immediately, no further writes occur, and no Done is issued. After release the block restarts from IDLE.

Optional Feature:
- TRANSPARENT_EN defined: a pixel whose sprite_data == TRANSP_KEY has fb_we forced to 0. Timing and Done are unchanged.
- TRANSPARENT_EN undefined: every in-bounds pixel is written.

Test Plan:
- Single 8x8 tile, with ROM model data = addr[3:0]: request NewDrawX = 0, NewDrawY = 0, NewSpriteX = 24, NewSpriteY = 16, is_8 = 1.
  - First sprite_addr = 2072.
  - 64 writes: fb_addr 0..7, 168..175, ..., 1176..1183, each with correct data.
  - Done_Draw_FB is high in cycle 66 only.
- Back-to-back tiles: a requester model holds Draw_FB_EN high and advances DrawX by 8 on each Done, 19 tiles in a row.
  - 19 Done pulses spaced 67 cycles apart.
  - No pixel is duplicated or dropped, and every tile uses its own coordinates.
- Clipped 16x16 tile: request NewDrawX = 160, NewDrawY = 96, is_8 = 0.
  - Only 64 writes occur (x 160..167, y 96..103).
  - Done_Draw_FB is asserted in cycle 258.
- Async reset mid-tile: assert RESET_N = 0 after the 30th write.
  - fb_we drops the same cycle, and Done is never asserted.
  - After release, with Draw_FB_EN held high, the tile restarts with its first sprite_addr.
- Transparency, with a ROM returning 0 at even addresses and TRANSP_KEY = 0:
  - With TRANSPARENT_EN defined: 32 writes for an 8x8 tile.
  - With TRANSPARENT_EN undefined: 64 writes.
  - Done timing is identical in both builds.
- Draw_FB_EN deasserted in FETCH cycle 10: all 64 writes still occur, Done pulses once, and the block then stays in IDLE.
